// File: rtl/twofish_pkg.sv
// Twofish key-schedule primitives: q0/q1 permutations, GF(2^8) MDS multiplies, rol32.
// Latency: purely combinational helper functions, no registers.
// Backpressure: none; functions are evaluated inside callers' combinational logic.
package twofish_pkg;

    // 4-bit t-tables, entry 0 in the most significant nibble.
    localparam logic [63:0] Q0_T0 = 64'h817D6F320B59ECA4;
    localparam logic [63:0] Q0_T1 = 64'hECB81235F4A6709D;
    localparam logic [63:0] Q0_T2 = 64'hBA5E6D90C8F32471;
    localparam logic [63:0] Q0_T3 = 64'hD7F4126E9B3085CA;
    localparam logic [63:0] Q1_T0 = 64'h28BDF76E31940AC5;
    localparam logic [63:0] Q1_T1 = 64'h1E2B4C376DA5F908;
    localparam logic [63:0] Q1_T2 = 64'h4C75169A0ED82B3F;
    localparam logic [63:0] Q1_T3 = 64'hB951C3DE647F208A;

    localparam logic [7:0]  MDS_5B = 8'h5B;
    localparam logic [7:0]  MDS_EF = 8'hEF;
    // Low byte of the field polynomial x^8+x^6+x^5+x^3+1.
    localparam logic [7:0]  GF_POLY_LO = 8'h69;
    localparam logic [31:0] RHO = 32'h01010101;

    function automatic logic [3:0] t_lookup(input logic [63:0] tab, input logic [3:0] idx);
        logic [63:0] s;
        s = tab << {idx, 2'b00};
        return s[63:60];
    endfunction

    // sel = 0 selects q0, sel = 1 selects q1.
    function automatic logic [7:0] q_perm(input logic sel, input logic [7:0] v);
        logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
        a0 = v[7:4];
        b0 = v[3:0];
        a1 = a0 ^ b0;
        b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
        a2 = t_lookup(sel ? Q1_T0 : Q0_T0, a1);
        b2 = t_lookup(sel ? Q1_T1 : Q0_T1, b1);
        a3 = a2 ^ b2;
        b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
        a4 = t_lookup(sel ? Q1_T2 : Q0_T2, a3);
        b4 = t_lookup(sel ? Q1_T3 : Q0_T3, b3);
        return {b4, a4};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? GF_POLY_LO : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] mul_5b(input logic [7:0] a);
        return gf_mul(a, MDS_5B);
    endfunction

    function automatic logic [7:0] mul_ef(input logic [7:0] a);
        return gf_mul(a, MDS_EF);
    endfunction

    function automatic logic [31:0] rol32(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

endpackage

// File: rtl/twofish_keygen_if.sv
// Subkey request bus: index and key in, subkey pair out.
// Latency: carries the 1-cycle registered result of the key generator.
// Backpressure: none; a new request may be presented every cycle.
interface twofish_keygen_if;
    logic [4:0]   x;
    logic [127:0] keyM;
    logic [31:0]  k0;
    logic [31:0]  k1;

    modport master (output x, output keyM, input k0, input k1);
    modport slave  (input x, input keyM, output k0, output k1);
endinterface

// File: rtl/twofish_h.sv
// Twofish h-function for 128-bit keys: replicated byte through 3 q-levels and MDS.
// Latency: combinational. Ports: b (index byte), l0/l1 (key words), y (result word).
// Backpressure: none.
module twofish_h
    import twofish_pkg::*;
(
    input  logic [7:0]  b,
    input  logic [31:0] l0,
    input  logic [31:0] l1,
    output logic [31:0] y
);

    logic [31:0] xw;
    logic [7:0]  z0, z1, z2, z3;

    assign xw = RHO * {24'h000000, b};

    // Innermost q first, then key byte from l1, middle q, key byte from l0, outer q.
    assign z0 = q_perm(1'b1, q_perm(1'b0, q_perm(1'b0, xw[7:0])   ^ l1[7:0])   ^ l0[7:0]);
    assign z1 = q_perm(1'b0, q_perm(1'b0, q_perm(1'b1, xw[15:8])  ^ l1[15:8])  ^ l0[15:8]);
    assign z2 = q_perm(1'b1, q_perm(1'b1, q_perm(1'b0, xw[23:16]) ^ l1[23:16]) ^ l0[23:16]);
    assign z3 = q_perm(1'b0, q_perm(1'b1, q_perm(1'b1, xw[31:24]) ^ l1[31:24]) ^ l0[31:24]);

    assign y[7:0]   = z0         ^ mul_ef(z1) ^ mul_5b(z2) ^ mul_5b(z3);
    assign y[15:8]  = mul_5b(z0) ^ mul_ef(z1) ^ mul_ef(z2) ^ z3;
    assign y[23:16] = mul_ef(z0) ^ mul_5b(z1) ^ z2         ^ mul_ef(z3);
    assign y[31:24] = mul_ef(z0) ^ z1         ^ mul_ef(z2) ^ mul_5b(z3);

endmodule

// File: rtl/twofish_keygen.sv
// Twofish 128-bit-key round subkey generator: K[2x], K[2x+1] from index x and key.
// Latency: 1 cycle (combinational core into a 64-bit output register). Ports: clk, rst, bus (slave).
// Backpressure: none; accepts a new index/key every cycle, x = 20..31 uses the same formula.
module twofish_keygen
    import twofish_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    twofish_keygen_if.slave bus
);

    logic [31:0] m0, m1, m2, m3;
    logic [7:0]  idx_even, idx_odd;
    logic [31:0] h_a, h_b, b_rot;
    logic [31:0] pht_0, pht_1;
    logic [31:0] k0_q, k1_q;

    assign m0 = bus.keyM[31:0];
    assign m1 = bus.keyM[63:32];
    assign m2 = bus.keyM[95:64];
    assign m3 = bus.keyM[127:96];

    assign idx_even = {2'b00, bus.x, 1'b0};
    assign idx_odd  = {2'b00, bus.x, 1'b1};

    // Even words (M0, M2) feed A, odd words (M1, M3) feed B.
    twofish_h u_h_a (.b(idx_even), .l0(m0), .l1(m2), .y(h_a));
    twofish_h u_h_b (.b(idx_odd),  .l0(m1), .l1(m3), .y(h_b));

    assign b_rot = rol32(h_b, 8);
    assign pht_0 = h_a + b_rot;
    assign pht_1 = h_a + {b_rot[30:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k0_q <= '0;
            k1_q <= '0;
        end else begin
            k0_q <= pht_0;
            k1_q <= rol32(pht_1, 9);
        end
    end

    assign bus.k0 = k0_q;
    assign bus.k1 = k1_q;

endmodule

// File: tb/tb_twofish_keygen.sv
// Self-checking bench for twofish_keygen against a table-driven Twofish key-schedule model.
// Latency: expects results one clock after inputs are presented.
// Backpressure: none; inputs change every cycle.
module tb_twofish_keygen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    twofish_keygen_if bus();

    twofish_keygen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // t-tables [q][stage][nibble]
    int tt [2][4][16] = '{
        '{ '{8,1,7,13,6,15,3,2,0,11,5,9,14,12,10,4},
           '{14,12,11,8,1,2,3,5,15,4,10,6,7,0,9,13},
           '{11,10,5,14,6,13,9,0,12,8,15,3,2,4,7,1},
           '{13,7,15,4,1,2,6,14,9,11,3,0,8,5,12,10} },
        '{ '{2,8,11,13,15,7,6,14,3,1,9,4,0,10,12,5},
           '{1,14,2,11,4,12,3,7,6,13,10,5,15,9,0,8},
           '{4,12,7,5,1,6,9,10,0,14,13,8,2,11,3,15},
           '{11,9,5,1,12,3,13,14,6,4,7,15,2,0,8,10} } };

    int mds  [4][4] = '{ '{'h01,'hEF,'h5B,'h5B}, '{'h5B,'hEF,'hEF,'h01},
                         '{'hEF,'h5B,'h01,'hEF}, '{'hEF,'h01,'hEF,'h5B} };
    // which q at each level (innermost first) for output byte n
    int qsel [4][3] = '{ '{0,0,1}, '{1,0,0}, '{0,1,1}, '{1,1,0} };

    int qt [2][256];

    function automatic int ror4(input int v);
        return ((v >> 1) | (v << 3)) & 15;
    endfunction

    function automatic int build_q(input int s, input int v);
        int a0, b0, a1, b1, a2, b2, a3, b3;
        a0 = v >> 4;          b0 = v & 15;
        a1 = a0 ^ b0;         b1 = a0 ^ ror4(b0) ^ ((8 * a0) & 15);
        a2 = tt[s][0][a1];    b2 = tt[s][1][b1];
        a3 = a2 ^ b2;         b3 = a2 ^ ror4(b2) ^ ((8 * a2) & 15);
        return 16 * tt[s][3][b3] + tt[s][2][a3];
    endfunction

    function automatic int gmul(input int a, input int c);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++)
            if (((c >> i) & 1) == 1) p = p ^ (a << i);
        for (int k = 14; k >= 8; k--)
            if (((p >> k) & 1) == 1) p = p ^ ('h169 << (k - 8));
        return p & 255;
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] h_ref(input int b, input logic [31:0] l0, input logic [31:0] l1);
        int z [4];
        int t, acc;
        logic [31:0] r;
        for (int n = 0; n < 4; n++) begin
            t = qt[qsel[n][0]][b];
            t = qt[qsel[n][1]][t ^ int'(l1[8*n +: 8])];
            t = qt[qsel[n][2]][t ^ int'(l0[8*n +: 8])];
            z[n] = t;
        end
        r = '0;
        for (int row = 0; row < 4; row++) begin
            acc = 0;
            for (int c = 0; c < 4; c++) acc = acc ^ gmul(mds[row][c], z[c]);
            r[8*row +: 8] = acc[7:0];
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_pair(input int xi, input logic [127:0] key);
        logic [31:0] a, b, e0, e1;
        a  = h_ref(2 * xi,     key[31:0],  key[95:64]);
        b  = rol(h_ref(2 * xi + 1, key[63:32], key[127:96]), 8);
        e0 = a + b;
        e1 = rol(a + 2 * b, 9);
        return {e1, e0};
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        bus.x = 5'($urandom);
        bus.keyM = rand_key();
        #2 rst = 1'b1;
        #1;
        if (bus.k0 !== 32'h0 || bus.k1 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_async: k0=%h k1=%h expected 0/0", bus.k0, bus.k1);
        end
        n_cmp++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.k0 !== 32'h0 || bus.k1 !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: k0=%h k1=%h expected 0/0", i, bus.k0, bus.k1);
            end
            n_cmp++;
            bus.x = 5'($urandom);
            bus.keyM = rand_key();
        end
    endtask

    task automatic test_known();
        logic [31:0] want0 [2] = '{32'h52C54DDE, 32'h7CAC9D4A};
        logic [31:0] want1 [2] = '{32'h11F0626D, 32'h4D1B4AAA};
        rst = 1'b0;
        bus.keyM = '0;
        for (int i = 0; i < 2; i++) begin
            bus.x = 5'(i);
            @(posedge clk); #1;
            if (bus.k0 !== want0[i] || bus.k1 !== want1[i]) begin
                n_bad++;
                $display("FAIL zero_key_x%0d: k0=%h k1=%h expected %h/%h", i, bus.k0, bus.k1, want0[i], want1[i]);
            end
            n_cmp++;
        end
    endtask

    task automatic test_latency();
        logic [63:0] old_e, new_e;
        bus.keyM = rand_key();
        bus.x = 5'd5;
        old_e = ref_pair(5, bus.keyM);
        @(posedge clk); #1;
        bus.x = 5'd6;
        new_e = ref_pair(6, bus.keyM);
        #3;
        if ({bus.k1, bus.k0} !== old_e) begin
            n_bad++;
            $display("FAIL latency_hold: got %h expected %h", {bus.k1, bus.k0}, old_e);
        end
        n_cmp++;
        @(posedge clk); #1;
        if ({bus.k1, bus.k0} !== new_e) begin
            n_bad++;
            $display("FAIL latency_update: got %h expected %h", {bus.k1, bus.k0}, new_e);
        end
        n_cmp++;
    endtask

    task automatic test_zero_sweep();
        logic [63:0] e;
        bus.keyM = '0;
        for (int i = 0; i < 20; i++) begin
            bus.x = 5'(i);
            e = ref_pair(i, '0);
            @(posedge clk); #1;
            if ({bus.k1, bus.k0} !== e) begin
                n_bad++;
                $display("FAIL zero_sweep x=%0d: got %h expected %h", i, {bus.k1, bus.k0}, e);
            end
            n_cmp++;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        int xi;
        bus.keyM = rand_key();
        for (int i = 0; i < 200; i++) begin
            xi = (i < 12) ? 20 + i : int'($urandom_range(0, 31));
            bus.x = 5'(xi);
            if ($urandom_range(0, 1) == 1) bus.keyM = rand_key();
            e = ref_pair(xi, bus.keyM);
            @(posedge clk); #1;
            if ({bus.k1, bus.k0} !== e) begin
                n_bad++;
                $display("FAIL back_to_back[%0d] x=%0d: got %h expected %h", i, xi, {bus.k1, bus.k0}, e);
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] e;
        bus.keyM = rand_key();
        for (int i = 0; i < 20; i++) begin
            bus.x = 5'(i);
            e = ref_pair(i, bus.keyM);
            if (i == 10) begin
                #3 rst = 1'b1;
                #1;
                if (bus.k0 !== 32'h0 || bus.k1 !== 32'h0) begin
                    n_bad++;
                    $display("FAIL reset_mid_async: k0=%h k1=%h expected 0/0", bus.k0, bus.k1);
                end
                n_cmp++;
                @(posedge clk); #1;
                if (bus.k0 !== 32'h0 || bus.k1 !== 32'h0) begin
                    n_bad++;
                    $display("FAIL reset_mid_hold: k0=%h k1=%h expected 0/0", bus.k0, bus.k1);
                end
                n_cmp++;
                bus.x = 5'd13;
                e = ref_pair(13, bus.keyM);
                #2 rst = 1'b0;
                #1;
                if (bus.k0 !== 32'h0 || bus.k1 !== 32'h0) begin
                    n_bad++;
                    $display("FAIL reset_mid_release: k0=%h k1=%h expected 0/0", bus.k0, bus.k1);
                end
                n_cmp++;
            end
            @(posedge clk); #1;
            if ({bus.k1, bus.k0} !== e) begin
                n_bad++;
                $display("FAIL reset_mid_sweep[%0d]: got %h expected %h", i, {bus.k1, bus.k0}, e);
            end
            n_cmp++;
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int v = 0; v < 256; v++)
                qt[s][v] = build_q(s, v);
        bus.x = '0;
        bus.keyM = '0;
        test_reset();
        test_known();
        test_latency();
        test_zero_sweep();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
